serial_alu: RTL and testbench

- Bit-serial counterpart of the parallel 24-bit ALU. Where the parallel ALU ripples one slice per bit in a single cycle, this block runs one 1-bit slice per clock for WIDTH clocks.
- It takes the same control encoding: AInvert, BInvert, CIN and 3-bit Op (0 AND, 1 OR, 2 ADD, 3 SLT, 4 XOR).
- Used as a low-area multi-cycle execution unit beside the single-cycle datapath. A start/busy/done handshake makes it stall-capable.

---
 rtl/serial_alu.sv | 116 +++++++++++
 tb/tb_serial_alu.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_alu.sv
// Bit-serial ALU: one 1-bit slice per clock over WIDTH clocks, with a start/busy/done handshake.
// Supports AND, OR, ADD, SLT and XOR with optional operand inversion and carry-in.
module serial_alu #(
  parameter int unsigned WIDTH = 24
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             AInvert,
  input  logic             BInvert,
  input  logic             CIN,
  input  logic [2:0]       Op,
  output logic [WIDTH-1:0] Result,
  output logic             CarryOut,
  output logic             Overflow,
  output logic             Zero,
  output logic             Busy,
  output logic             Done
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh, b_sh, res_sh;
  logic             ainv, binv, carry;
  logic [2:0]       op;
  logic [CW-1:0]    cnt;

  logic             ma, mb, sum, cnext, slice, arith, ovf, last;
  logic [WIDTH-1:0] res_next, final_res;

  always_comb begin
    ma    = a_sh[0] ^ ainv;
    mb    = b_sh[0] ^ binv;
    sum   = ma ^ mb ^ carry;
    cnext = (ma & mb) | (ma & carry) | (mb & carry);
    case (op)
      3'd0:    slice = ma & mb;
      3'd1:    slice = ma | mb;
      3'd2:    slice = sum;
      3'd4:    slice = ma ^ mb;
      default: slice = 1'b0;
    endcase
    res_next = {slice, res_sh[WIDTH-1:1]};
    arith    = (op == 3'd2) || (op == 3'd3);
    // carry still holds the carry into the MSB slice on the last step
    ovf      = carry ^ cnext;
    last     = (cnt == CW'(WIDTH - 1));
    final_res = res_next;
    if (op == 3'd3) final_res[0] = sum ^ ovf;
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state    <= IDLE;
      a_sh     <= '0;
      b_sh     <= '0;
      res_sh   <= '0;
      ainv     <= 1'b0;
      binv     <= 1'b0;
      carry    <= 1'b0;
      op       <= '0;
      cnt      <= '0;
      Result   <= '0;
      CarryOut <= 1'b0;
      Overflow <= 1'b0;
      Zero     <= 1'b1;
      Busy     <= 1'b0;
      Done     <= 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          Done <= 1'b0;
          if (Start) begin
            a_sh   <= A;
            b_sh   <= B;
            res_sh <= '0;
            ainv   <= AInvert;
            binv   <= BInvert;
            carry  <= CIN;
            op     <= Op;
            cnt    <= '0;
            Busy   <= 1'b1;
            state  <= RUN;
          end else begin
            state  <= IDLE;
          end
        end
        RUN: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          res_sh <= res_next;
          carry  <= cnext;
          if (last) begin
            cnt      <= '0;
            Result   <= final_res;
            CarryOut <= arith & cnext;
            Overflow <= arith & ovf;
            Zero     <= (final_res == '0);
            Busy     <= 1'b0;
            Done     <= 1'b1;
            state    <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_alu.sv
// Self-checking bench for serial_alu: arithmetic reference model checked every cycle,
// plus directed vectors with literal expected results.
module tb_serial_alu;

  localparam int unsigned W = 24;

  logic         Clock = 1'b0;
  logic         Reset = 1'b0;
  logic         Start = 1'b0;
  logic [W-1:0] A = '0, B = '0;
  logic         AInvert = 1'b0, BInvert = 1'b0, CIN = 1'b0;
  logic [2:0]   Op = '0;
  logic [W-1:0] Result;
  logic         CarryOut, Overflow, Zero, Busy, Done;

  serial_alu #(.WIDTH(W)) dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .A(A), .B(B),
    .AInvert(AInvert), .BInvert(BInvert), .CIN(CIN), .Op(Op),
    .Result(Result), .CarryOut(CarryOut), .Overflow(Overflow),
    .Zero(Zero), .Busy(Busy), .Done(Done)
  );

  always #5 Clock = ~Clock;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: returns {CarryOut, Overflow, Result} from plain arithmetic
  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic ai, input logic bi, input logic cin,
                                         input logic [2:0] op);
    logic [W-1:0] ma, mb, res;
    longint usum, ssum, lim;
    logic co, ov;
    ma   = ai ? ~a : a;
    mb   = bi ? ~b : b;
    usum = longint'(ma) + longint'(mb) + longint'(cin);
    ssum = longint'($signed(ma)) + longint'($signed(mb)) + longint'(cin);
    lim  = longint'(1) << (W - 1);
    co   = usum[W];
    ov   = (ssum >= lim) || (ssum < -lim);
    case (op)
      3'd0: res = ma & mb;
      3'd1: res = ma | mb;
      3'd2: res = usum[W-1:0];
      3'd3: res = (ssum < 0) ? W'(1) : W'(0);
      3'd4: res = ma ^ mb;
      default: res = '0;
    endcase
    if (op != 3'd2 && op != 3'd3) begin
      co = 1'b0;
      ov = 1'b0;
    end
    return {co, ov, res};
  endfunction

  // Cycle-level expectation: cycles left of the current operation and held outputs
  int           m_left = 0;
  logic         m_busy = 1'b0, m_done = 1'b0;
  logic [W-1:0] m_res = '0;
  logic         m_co = 1'b0, m_ov = 1'b0;
  logic [W-1:0] c_a, c_b;
  logic         c_ai, c_bi, c_cin;
  logic [2:0]   c_op;

  always @(posedge Clock) begin
    if (!Reset) begin
      m_left = 0; m_busy = 1'b0; m_done = 1'b0;
      m_res = '0; m_co = 1'b0; m_ov = 1'b0;
    end else if (m_busy) begin
      m_left--;
      if (m_left == 0) begin
        m_busy = 1'b0;
        m_done = 1'b1;
        {m_co, m_ov, m_res} = model(c_a, c_b, c_ai, c_bi, c_cin, c_op);
      end
    end else begin
      m_done = 1'b0;
      if (Start) begin
        c_a = A; c_b = B; c_ai = AInvert; c_bi = BInvert; c_cin = CIN; c_op = Op;
        m_busy = 1'b1;
        m_left = W;
      end
    end
  end

  always @(negedge Clock) begin
    if (chk_en) begin
      check("busy", Busy, m_busy);
      check("done", Done, m_done);
      if (!m_busy) begin
        check("result", Result, m_res);
        check("carryout", CarryOut, m_co);
        check("overflow", Overflow, m_ov);
        check("zero", Zero, m_res == '0);
      end
    end
  end

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic ai,
                        input logic bi, input logic cin, input logic [2:0] op);
    A = a; B = b; AInvert = ai; BInvert = bi; CIN = cin; Op = op;
    Start = 1'b1;
    @(negedge Clock);
    Start = 1'b0;
  endtask

  // Called at the first negedge after acceptance; returns the cycle of Done and Busy count
  task automatic wait_done(output int n, output int nb);
    n  = 1;
    nb = 0;
    while (!Done && n < 100) begin
      if (Busy) nb++;
      @(negedge Clock);
      n++;
    end
    check("done_seen", Done, 1'b1);
  endtask

  task automatic expect_out(input string name, input logic [W-1:0] r, input logic co,
                            input logic ov, input logic z);
    check({name, "_result"}, Result, r);
    check({name, "_carry"}, CarryOut, co);
    check({name, "_ovf"}, Overflow, ov);
    check({name, "_zero"}, Zero, z);
  endtask

  initial begin
    int n, nb;
    bit seen;
    @(negedge Clock);
    chk_en = 1'b1;
    @(negedge Clock);
    check("rst_zero", Zero, 1'b1);
    check("rst_result", Result, 0);
    check("rst_busy", Busy, 1'b0);
    Reset = 1'b1;
    repeat (2) @(negedge Clock);

    run_op(24'h00000F, 24'h000001, 0, 0, 0, 3'd2);
    wait_done(n, nb);
    check("add_latency", n, 25);
    check("add_busy_cycles", nb, 24);
    expect_out("add", 24'h000010, 0, 0, 0);
    repeat (2) @(negedge Clock);

    run_op(24'd5, 24'd7, 0, 1, 1, 3'd2);
    wait_done(n, nb);
    expect_out("sub_neg", 24'hFFFFFE, 0, 0, 0);
    run_op(24'd7, 24'd7, 0, 1, 1, 3'd2);
    wait_done(n, nb);
    expect_out("sub_zero", 24'h000000, 1, 0, 1);

    run_op(24'h800000, 24'h000001, 0, 1, 1, 3'd3);
    wait_done(n, nb);
    check("slt_min_result", Result, 24'h000001);
    run_op(24'h7FFFFF, 24'h800000, 0, 1, 1, 3'd3);
    wait_done(n, nb);
    check("slt_max_result", Result, 24'h000000);
    check("slt_max_ovf", Overflow, 1'b1);

    run_op(24'hF0F0F0, 24'h0F0F00, 1, 1, 0, 3'd0);
    wait_done(n, nb);
    expect_out("nor", 24'h00000F, 0, 0, 0);
    run_op(24'hF0F0F0, 24'h0F0F00, 0, 0, 0, 3'd4);
    wait_done(n, nb);
    expect_out("xor", 24'hFFFFF0, 0, 0, 0);
    repeat (2) @(negedge Clock);

    run_op(24'h123456, 24'h111111, 0, 0, 0, 3'd2);
    repeat (9) @(negedge Clock);
    A = 24'hFFFFFF; B = 24'h000000; Op = 3'd0; Start = 1'b1;
    @(negedge Clock);
    Start = 1'b0;
    wait_done(n, nb);
    expect_out("ignore_start", 24'h234567, 0, 0, 0);

    run_op(24'h000003, 24'h000004, 0, 0, 0, 3'd4);
    check("b2b_busy", Busy, 1'b1);
    wait_done(n, nb);
    check("b2b_latency", n, 25);
    check("b2b_result", Result, 24'h000007);
    repeat (2) @(negedge Clock);

    run_op(24'hAAAAAA, 24'h555555, 0, 0, 0, 3'd1);
    repeat (11) @(negedge Clock);
    Reset = 1'b0;
    @(negedge Clock);
    check("abort_busy", Busy, 1'b0);
    check("abort_done", Done, 1'b0);
    check("abort_result", Result, 0);
    check("abort_zero", Zero, 1'b1);
    Reset = 1'b1;
    seen = 1'b0;
    repeat (30) begin
      @(negedge Clock);
      if (Done) seen = 1'b1;
    end
    check("abort_no_done", seen, 1'b0);
    run_op(24'hAAAAAA, 24'h555555, 0, 0, 0, 3'd1);
    wait_done(n, nb);
    expect_out("after_abort", 24'hFFFFFF, 0, 0, 0);

    run_op(24'hFFFFFF, 24'hFFFFFF, 0, 0, 1, 3'd5);
    wait_done(n, nb);
    expect_out("op5", 24'h000000, 0, 0, 1);
    repeat (3) @(negedge Clock);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
